// File: rtl/fsm_door_ctrl.sv
// rtl/fsm_door_ctrl.sv - door/gate motor controller FSM with dead time, travel timeout and auto-close
//
// Purpose:
//   Drives the up/down door motor from keys and end-stop sensors. Motor
//   reversals always pass through a motor-off PAUSE. Travel longer than
//   MOVE_TIMEOUT locks the controller in FAULT until reset. The door can
//   close automatically after AUTO_CLOSE cycles in OPEN. A red warning light
//   blinks while the door moves.
//
// Ports:
//   clk2m        in   clock, rising edge
//   rst          in   synchronous, active-high reset
//   key_up       in   open request (level, asynchronous)
//   key_down     in   close request (level, asynchronous)
//   sense_up     in   end stop, door fully open (asynchronous)
//   sense_down   in   end stop, door fully closed (asynchronous)
//   ml           out  motor drives door up
//   mr           out  motor drives door down
//   light_red    out  warning light (steady or blinking)
//   light_green  out  door open indicator
//   fault        out  FAULT state active
module fsm_door_ctrl #(
   parameter int MOVE_TIMEOUT = 4000,
   parameter int REV_GAP      = 4,
   parameter int BLINK_HALF   = 1000,
   parameter int AUTO_CLOSE   = 0
) (
   input  logic clk2m,
   input  logic rst,
   input  logic key_up,
   input  logic key_down,
   input  logic sense_up,
   input  logic sense_down,
   output logic ml,
   output logic mr,
   output logic light_red,
   output logic light_green,
   output logic fault
);

   localparam int MAX_A   = (MOVE_TIMEOUT > REV_GAP) ? MOVE_TIMEOUT : REV_GAP;
   localparam int MAX_B   = (BLINK_HALF > AUTO_CLOSE) ? BLINK_HALF : AUTO_CLOSE;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam bit AUTO_EN = (AUTO_CLOSE > 0);

   // Terminal counts: a state is held for exactly N cycles when it leaves
   // on the cycle the counter shows N-1.
   localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(REV_GAP - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
   localparam logic [CNT_W-1:0] AUTO_LAST  = CNT_W'(AUTO_EN ? AUTO_CLOSE - 1 : 0);

   typedef enum logic [2:0] {
      ST_UNKNOWN,
      ST_CLOSED,
      ST_OPENING,
      ST_OPEN,
      ST_CLOSING,
      ST_PAUSE,
      ST_FAULT
   } state_t;

   // Synchroniser bit order: {key_up, key_down, sense_up, sense_down}
   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   state_t           state_q, state_d;
   state_t           target_q, target_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_q, blink_d;
   logic             ml_q, ml_d;
   logic             mr_q, mr_d;
   logic             red_q, red_d;
   logic             green_q, green_d;
   logic             fault_q, fault_d;

   logic ku_s, kd_s, su_s, sd_s;
   logic close_req;
   logic blinking;

   assign ku_s = sync2_q[3];
   assign kd_s = sync2_q[2];
   assign su_s = sync2_q[1];
   assign sd_s = sync2_q[0];

   // Both keys together count as an open request, so close needs key_up low.
   assign close_req = kd_s & ~ku_s;

   always_comb begin
      sync1_d  = {key_up, key_down, sense_up, sense_down};
      sync2_d  = sync1_q;
      state_d  = state_q;
      target_d = target_q;

      // Both end stops active is physically impossible: treat as a sensor fault.
      if (state_q != ST_FAULT && su_s && sd_s) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_UNKNOWN: begin
               if (sd_s)      state_d = ST_CLOSED;
               else if (su_s) state_d = ST_OPEN;
               else if (ku_s) state_d = ST_OPENING;
               else if (kd_s) state_d = ST_CLOSING;
            end
            ST_CLOSED: begin
               if (ku_s) state_d = ST_OPENING;
            end
            ST_OPENING: begin
               // End stop is tested before the timeout so arrival on the last cycle still counts.
               if (su_s) begin
                  state_d = ST_OPEN;
               end else if (close_req) begin
                  state_d  = ST_PAUSE;
                  target_d = ST_CLOSING;
               end else if (cnt_q == MOVE_LAST) begin
                  state_d = ST_FAULT;
               end
            end
            ST_OPEN: begin
               if (close_req) begin
                  state_d = ST_CLOSING;
               end else if (AUTO_EN && !ku_s && cnt_q == AUTO_LAST) begin
                  state_d = ST_CLOSING;
               end
            end
            ST_CLOSING: begin
               if (sd_s) begin
                  state_d = ST_CLOSED;
               end else if (ku_s) begin
                  state_d  = ST_PAUSE;
                  target_d = ST_OPENING;
               end else if (cnt_q == MOVE_LAST) begin
                  state_d = ST_FAULT;
               end
            end
            ST_PAUSE: begin
               if (cnt_q == GAP_LAST) state_d = target_q;
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_UNKNOWN;
            end
         endcase
      end

      // Shared counter: travel time, dead time or auto-close time, restarted on every state change.
      cnt_d = '0;
      if (state_d == state_q) begin
         case (state_q)
            ST_OPENING, ST_CLOSING, ST_PAUSE: cnt_d = cnt_q + CNT_W'(1);
            ST_OPEN:  cnt_d = (ku_s || !AUTO_EN) ? '0 : cnt_q + CNT_W'(1);
            default:  cnt_d = '0;
         endcase
      end

      // Blink phase restarts dark on every entry into a moving/paused state.
      blinking = (state_d == ST_OPENING) || (state_d == ST_CLOSING) || (state_d == ST_PAUSE);
      if (!blinking || state_d != state_q) begin
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end else begin
         blink_cnt_d = blink_cnt_q + CNT_W'(1);
         blink_d     = blink_q;
      end

      // Outputs are registered copies of the decode of the next state.
      ml_d    = (state_d == ST_OPENING);
      mr_d    = (state_d == ST_CLOSING);
      green_d = (state_d == ST_OPEN);
      fault_d = (state_d == ST_FAULT);
      red_d   = (state_d == ST_UNKNOWN) || (state_d == ST_FAULT) || (blinking && blink_d);
   end

   always_ff @(posedge clk2m) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         state_q     <= ST_UNKNOWN;
         target_q    <= ST_OPENING;
         cnt_q       <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         ml_q        <= 1'b0;
         mr_q        <= 1'b0;
         red_q       <= 1'b1;
         green_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         ml_q        <= ml_d;
         mr_q        <= mr_d;
         red_q       <= red_d;
         green_q     <= green_d;
         fault_q     <= fault_d;
      end
   end

   assign ml          = ml_q;
   assign mr          = mr_q;
   assign light_red   = red_q;
   assign light_green = green_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_fsm_door_ctrl.sv
// tb/tb_fsm_door_ctrl.sv - self-checking bench for fsm_door_ctrl
module tb_fsm_door_ctrl;

   localparam int MOVE_TIMEOUT = 40;
   localparam int REV_GAP      = 4;
   localparam int BLINK_HALF   = 2;
   localparam int AUTO_CLOSE   = 20;

   // Output vector bit positions: {ml, mr, light_red, light_green, fault}
   localparam int B_ML    = 4;
   localparam int B_MR    = 3;
   localparam int B_RED   = 2;
   localparam int B_GREEN = 1;
   localparam int B_FAULT = 0;

   logic clk2m = 1'b0;
   logic rst = 1'b1;
   logic key_up = 1'b0;
   logic key_down = 1'b0;
   logic sense_up = 1'b0;
   logic sense_down = 1'b0;
   logic ml, mr, light_red, light_green, fault;
   logic [4:0] outs;

   int n_checks = 0;
   int n_pass = 0;

   assign outs = {ml, mr, light_red, light_green, fault};

   fsm_door_ctrl #(
      .MOVE_TIMEOUT(MOVE_TIMEOUT),
      .REV_GAP(REV_GAP),
      .BLINK_HALF(BLINK_HALF),
      .AUTO_CLOSE(AUTO_CLOSE)
   ) dut (
      .clk2m(clk2m),
      .rst(rst),
      .key_up(key_up),
      .key_down(key_down),
      .sense_up(sense_up),
      .sense_down(sense_down),
      .ml(ml),
      .mr(mr),
      .light_red(light_red),
      .light_green(light_green),
      .fault(fault)
   );

   always #5 clk2m = ~clk2m;

   // Reference model: door mode plus time spent in it; inputs reach it two edges late.
   typedef enum {M_UNK, M_CLOSED, M_OPENING, M_OPEN, M_CLOSING, M_PAUSE, M_FAULT} mode_e;
   mode_e mode = M_UNK;
   mode_e after_pause = M_OPENING;
   int t = 0;
   int ac = 0;
   logic [3:0] d1 = '0;
   logic [3:0] d2 = '0;

   task automatic model_edge();
      logic ku, kd, su, sd;
      mode_e nxt;
      if (rst) begin
         mode = M_UNK;
         t = 0;
         ac = 0;
         d1 = '0;
         d2 = '0;
         return;
      end
      {ku, kd, su, sd} = d2;
      nxt = mode;
      if (mode != M_FAULT && su && sd) nxt = M_FAULT;
      else begin
         case (mode)
            M_UNK: begin
               if (sd) nxt = M_CLOSED;
               else if (su) nxt = M_OPEN;
               else if (ku) nxt = M_OPENING;
               else if (kd) nxt = M_CLOSING;
            end
            M_CLOSED: if (ku) nxt = M_OPENING;
            M_OPENING: begin
               if (su) nxt = M_OPEN;
               else if (kd && !ku) begin nxt = M_PAUSE; after_pause = M_CLOSING; end
               else if (t + 1 >= MOVE_TIMEOUT) nxt = M_FAULT;
            end
            M_OPEN: begin
               if (kd && !ku) nxt = M_CLOSING;
               else if (!ku && AUTO_CLOSE > 0 && ac + 1 >= AUTO_CLOSE) nxt = M_CLOSING;
            end
            M_CLOSING: begin
               if (sd) nxt = M_CLOSED;
               else if (ku) begin nxt = M_PAUSE; after_pause = M_OPENING; end
               else if (t + 1 >= MOVE_TIMEOUT) nxt = M_FAULT;
            end
            M_PAUSE: if (t + 1 >= REV_GAP) nxt = after_pause;
            default: nxt = mode;
         endcase
      end
      if (nxt != mode) begin
         t = 0;
         ac = 0;
      end else begin
         t = t + 1;
         ac = (mode == M_OPEN && ku) ? 0 : ac + 1;
      end
      mode = nxt;
      d2 = d1;
      d1 = {key_up, key_down, sense_up, sense_down};
   endtask

   function automatic logic [4:0] model_outs();
      logic red;
      case (mode)
         M_UNK, M_FAULT: red = 1'b1;
         M_OPENING, M_CLOSING, M_PAUSE: red = ((t / BLINK_HALF) % 2) == 1;
         default: red = 1'b0;
      endcase
      return {mode == M_OPENING, mode == M_CLOSING, red, mode == M_OPEN, mode == M_FAULT};
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk2m);
      model_edge();
      #1;
      check("model_outs", int'(outs), int'(model_outs()));
      check("ml_mr_exclusive", int'(ml & mr), 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Ticks until output bit idx equals val; the cycle count taken is itself checked.
   task automatic wait_for(input string tag, input int idx, input logic val, input int budget, input int exp_n);
      int n;
      logic [4:0] cur;
      n = 0;
      cur = outs;
      while (cur[idx] !== val && n < budget) begin
         tick();
         n++;
         cur = outs;
      end
      check(tag, n, exp_n);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold;
      int r;
      #1;
      // Reset with the door resting on the lower end stop
      sense_down = 1'b1;
      ticks(2);
      check("reset_outs", int'(outs), 5'b00100);
      rst = 1'b0;
      ticks(2);
      check("unknown_until_synced", int'(outs), 5'b00100);
      tick();
      check("closed_after_reset", int'(outs), 5'b00000);

      // One-cycle key_up pulse opens; red blinks with a 2-cycle half period
      key_up = 1'b1;
      sense_down = 1'b0;
      tick();
      key_up = 1'b0;
      wait_for("open_start", B_ML, 1'b1, 10, 2);
      tick();
      check("blink_t1", int'(outs), 5'b10000);
      tick();
      check("blink_t2", int'(outs), 5'b10100);
      tick();
      check("blink_t3", int'(outs), 5'b10100);
      tick();
      check("blink_t4", int'(outs), 5'b10000);
      ticks(4);
      sense_up = 1'b1;
      wait_for("open_reached", B_GREEN, 1'b1, 10, 3);
      check("open_outs", int'(outs), 5'b00010);

      // Auto-close after 20 idle cycles in OPEN, then close on the lower stop
      sense_up = 1'b0;
      wait_for("auto_close", B_MR, 1'b1, 30, 20);
      check("closing_outs", int'(outs), 5'b01000);
      ticks(7);
      sense_down = 1'b1;
      wait_for("closed_reached", B_MR, 1'b0, 10, 3);
      check("closed_outs", int'(outs), 5'b00000);

      // key_down while opening: exactly REV_GAP motor-off cycles, then down
      key_up = 1'b1;
      tick();
      key_up = 1'b0;
      sense_down = 1'b0;
      wait_for("reopen", B_ML, 1'b1, 10, 2);
      ticks(3);
      key_down = 1'b1;
      tick();
      key_down = 1'b0;
      wait_for("pause_entry", B_ML, 1'b0, 10, 2);
      check("pause_outs", int'(outs), 5'b00000);
      wait_for("rev_gap", B_MR, 1'b1, 10, 4);
      check("after_gap_outs", int'(outs), 5'b01000);

      // Both keys while closing count as key_up: reverse through PAUSE
      ticks(2);
      key_up = 1'b1;
      key_down = 1'b1;
      tick();
      key_up = 1'b0;
      key_down = 1'b0;
      wait_for("both_keys_pause", B_MR, 1'b0, 10, 2);
      wait_for("both_keys_opening", B_ML, 1'b1, 10, 4);
      sense_up = 1'b1;
      wait_for("open_again", B_GREEN, 1'b1, 10, 3);
      sense_up = 1'b0;
      ticks(2);
      key_down = 1'b1;
      tick();
      key_down = 1'b0;
      wait_for("key_close", B_MR, 1'b1, 10, 2);
      tick();
      sense_down = 1'b1;
      wait_for("closed_again", B_MR, 1'b0, 10, 3);

      // Both keys in CLOSED open the door
      key_up = 1'b1;
      key_down = 1'b1;
      tick();
      key_up = 1'b0;
      key_down = 1'b0;
      sense_down = 1'b0;
      wait_for("both_keys_closed", B_ML, 1'b1, 10, 2);

      // No end stop: FAULT after MOVE_TIMEOUT cycles, keys ignored, rst recovers
      wait_for("travel_timeout", B_FAULT, 1'b1, 60, 40);
      check("fault_outs", int'(outs), 5'b00101);
      key_up = 1'b1;
      ticks(5);
      key_up = 1'b0;
      key_down = 1'b1;
      ticks(5);
      key_down = 1'b0;
      check("fault_hold", int'(outs), 5'b00101);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_from_fault", int'(outs), 5'b00100);

      // Both end stops in OPEN -> FAULT
      sense_up = 1'b1;
      wait_for("unknown_to_open", B_GREEN, 1'b1, 10, 3);
      sense_down = 1'b1;
      wait_for("both_sensors_fault", B_FAULT, 1'b1, 10, 3);
      check("sensor_fault_outs", int'(outs), 5'b00101);
      rst = 1'b1;
      sense_up = 1'b0;
      sense_down = 1'b0;
      tick();
      rst = 1'b0;

      // Randomised phase, every cycle compared against the model
      for (int seg = 0; seg < 400; seg++) begin
         key_up = ($urandom % 5) == 0;
         key_down = ($urandom % 5) == 0;
         r = int'($urandom % 20);
         sense_up = (r <= 5);
         sense_down = (r == 0) || (r >= 6 && r <= 10);
         rst = ($urandom % 60) == 0;
         hold = rst ? 1 : int'($urandom_range(1, 15));
         ticks(hold);
         rst = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
